// File: rtl/seq_datapath_pkg.sv
// Shared types and the combinational ALU for the sequenced single-bus datapath.
// The ALU works on a fixed 64-bit word; callers zero-extend and truncate to DATA_W.
package seq_datapath_pkg;

    localparam int MAX_W = 64;
    typedef logic [MAX_W-1:0] word_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SHL  = 4'd4,
        OP_SHR  = 4'd5,
        OP_ROL  = 4'd6,
        OP_ROR  = 4'd7,
        OP_NEG  = 4'd8,
        OP_NOT  = 4'd9,
        OP_MUL  = 4'd10,
        OP_DIV  = 4'd11,
        OP_LDI  = 4'd12,
        OP_MFHI = 4'd13,
        OP_MFLO = 4'd14,
        OP_ILL  = 4'd15
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_Y    = 3'd1,
        ST_Z    = 3'd2,
        ST_DIV  = 3'd3,
        ST_WB   = 3'd4
    } state_e;

    function automatic logic uses_rs(op_e op);
        return op <= OP_DIV;
    endfunction

    // NEG and NOT are unary; every other arithmetic op reads rt as well.
    function automatic logic uses_rt(op_e op);
        return (op <= OP_ROR) || (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic word_t alu_f(op_e op, word_t a, word_t b, logic [5:0] sh, logic [6:0] w);
        word_t mask;
        word_t r;
        mask = (w >= 7'd64) ? '1 : ((word_t'(1) << w) - word_t'(1));
        case (op)
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_SHL:  r = a << sh;
            OP_SHR:  r = a >> sh;
            // Operands are zero-extended, so the wrapped bits come from a shift by (w - sh).
            OP_ROL:  r = (a << sh) | (a >> (w - {1'b0, sh}));
            OP_ROR:  r = (a >> sh) | (a << (w - {1'b0, sh}));
            OP_NEG:  r = word_t'(0) - a;
            OP_NOT:  r = ~a;
            default: r = '0;
        endcase
        return r & mask;
    endfunction

endpackage

// File: rtl/seq_bus_datapath_if.sv
// Host-side operation handshake: one operation accepted on op_valid && op_ready,
// retired with a single-cycle done pulse carrying err and result.
interface seq_bus_datapath_if #(
    parameter int DATA_W = 32,
    parameter int RA_W   = 4
);
    logic              op_valid;
    logic              op_ready;
    logic [3:0]        op_code;
    logic [RA_W-1:0]   op_rd;
    logic [RA_W-1:0]   op_rs;
    logic [RA_W-1:0]   op_rt;
    logic [DATA_W-1:0] op_imm;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] result;

    modport master (
        output op_valid, op_code, op_rd, op_rs, op_rt, op_imm,
        input  op_ready, done, err, result
    );

    modport slave (
        input  op_valid, op_code, op_rd, op_rs, op_rt, op_imm,
        output op_ready, done, err, result
    );
endinterface

// File: rtl/seq_divider.sv
// Signed restoring divider on operand magnitudes with a fixed DATA_W-step latency.
// Results are sign-corrected combinationally and hold until the next start.
module seq_divider #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              valid,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder,
    output logic              div0
);
    localparam int CW = $clog2(DATA_W);

    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] mag_b;
    logic [DATA_W-1:0] dvd_q;
    logic              q_neg;
    logic              r_neg;

    logic [DATA_W-1:0] mag_a_in;
    logic [DATA_W-1:0] mag_b_in;
    logic [DATA_W:0]   r_sh;
    logic [DATA_W:0]   diff;

    // |MIN| is 2^(DATA_W-1), which still fits as an unsigned magnitude.
    assign mag_a_in = dividend[DATA_W-1] ? (-dividend) : dividend;
    assign mag_b_in = divisor[DATA_W-1]  ? (-divisor)  : divisor;

    assign r_sh = {rem_q, quo_q[DATA_W-1]};
    assign diff = r_sh - {1'b0, mag_b};

    // valid marks the cycle whose closing edge performs the final step.
    assign valid = busy && (cnt == CW'(DATA_W - 1));

    assign quotient  = div0 ? '1    : (q_neg ? (-quo_q) : quo_q);
    assign remainder = div0 ? dvd_q : (r_neg ? (-rem_q) : rem_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt   <= '0;
            rem_q <= '0;
            quo_q <= '0;
            mag_b <= '0;
            dvd_q <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            div0  <= 1'b0;
            busy  <= 1'b0;
        end else if (start) begin
            cnt   <= '0;
            rem_q <= '0;
            quo_q <= mag_a_in;
            mag_b <= mag_b_in;
            dvd_q <= dividend;
            q_neg <= dividend[DATA_W-1] ^ divisor[DATA_W-1];
            r_neg <= dividend[DATA_W-1];
            div0  <= (divisor == '0);
            busy  <= 1'b1;
        end else if (busy) begin
            rem_q <= diff[DATA_W] ? r_sh[DATA_W-1:0] : diff[DATA_W-1:0];
            quo_q <= {quo_q[DATA_W-2:0], ~diff[DATA_W]};
            cnt   <= cnt + CW'(1);
            if (valid) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_bus_datapath.sv
// Single-bus datapath with its own micro-step sequencer: register file, Y/Z/HI/LO,
// and an IDLE -> T_Y -> (T_Z | DIV_IT) -> T_WB schedule per host operation.
module seq_bus_datapath
    import seq_datapath_pkg::*;
#(
    parameter int  DATA_W   = 32,
    parameter int  NUM_REGS = 16,
    localparam int RA_W     = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                reset,
    seq_bus_datapath_if.slave   bus,
    output logic [DATA_W-1:0]   hi_val,
    output logic [DATA_W-1:0]   lo_val,
    input  logic [RA_W-1:0]     dbg_addr,
    output logic [DATA_W-1:0]   dbg_data,
    output state_e              dbg_state
);
    localparam int SH_W = $clog2(DATA_W);

    state_e            state;
    op_e               op_q;
    logic [RA_W-1:0]   rd_q;
    logic [RA_W-1:0]   rs_q;
    logic [RA_W-1:0]   rt_q;
    logic [DATA_W-1:0] imm_q;
    logic              bad_q;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] y_q;
    logic [DATA_W-1:0] z_q;
    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic [DATA_W-1:0] result_q;
    logic              done_q;
    logic              err_q;

    function automatic logic in_range(logic [RA_W-1:0] idx);
        return int'(idx) < NUM_REGS;
    endfunction

    logic [DATA_W-1:0]   rs_val;
    logic [DATA_W-1:0]   rt_val;
    logic [5:0]          shamt;
    logic [DATA_W-1:0]   alu_res;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   wb_val;
    op_e                 op_in;
    logic                bad_in;

    logic              div_start;
    logic              div_busy;
    logic              div_valid;
    logic [DATA_W-1:0] div_quo;
    logic [DATA_W-1:0] div_rem;
    logic              div_zero;

    assign rs_val   = in_range(rs_q) ? regs[rs_q] : '0;
    assign rt_val   = in_range(rt_q) ? regs[rt_q] : '0;
    assign dbg_data = in_range(dbg_addr) ? regs[dbg_addr] : '0;

    assign shamt   = 6'(rt_val[SH_W-1:0]);
    assign alu_res = DATA_W'(alu_f(op_q, word_t'(y_q), word_t'(rt_val), shamt, 7'(DATA_W)));
    assign prod    = $signed({{DATA_W{y_q[DATA_W-1]}}, y_q})
                   * $signed({{DATA_W{rt_val[DATA_W-1]}}, rt_val});

    // Only the index fields an opcode actually uses can make it illegal.
    always_comb begin
        op_in  = op_e'(bus.op_code);
        bad_in = (op_in == OP_ILL) || !in_range(bus.op_rd)
              || (uses_rs(op_in) && !in_range(bus.op_rs))
              || (uses_rt(op_in) && !in_range(bus.op_rt));
    end

    always_comb begin
        case (op_q)
            OP_LDI:  wb_val = imm_q;
            OP_MFHI: wb_val = hi_q;
            OP_MFLO: wb_val = lo_q;
            OP_DIV:  wb_val = div_quo;
            default: wb_val = z_q;
        endcase
    end

    // The divider loads R[rs]/R[rt] on the same edge that loads Y.
    assign div_start = (state == ST_Y) && (op_q == OP_DIV);

    seq_divider #(.DATA_W(DATA_W)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .dividend  (rs_val),
        .divisor   (rt_val),
        .busy      (div_busy),
        .valid     (div_valid),
        .quotient  (div_quo),
        .remainder (div_rem),
        .div0      (div_zero)
    );

    assign bus.op_ready = (state == ST_IDLE) && !div_busy;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.result   = result_q;
    assign hi_val       = hi_q;
    assign lo_val       = lo_q;
    assign dbg_state    = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            op_q     <= OP_ADD;
            rd_q     <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            imm_q    <= '0;
            bad_q    <= 1'b0;
            y_q      <= '0;
            z_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.op_valid && bus.op_ready) begin
                        op_q  <= op_in;
                        rd_q  <= bus.op_rd;
                        rs_q  <= bus.op_rs;
                        rt_q  <= bus.op_rt;
                        imm_q <= bus.op_imm;
                        bad_q <= bad_in;
                        if (bad_in || (op_in inside {OP_LDI, OP_MFHI, OP_MFLO})) begin
                            state <= ST_WB;
                        end else begin
                            state <= ST_Y;
                        end
                    end
                end
                ST_Y: begin
                    y_q   <= rs_val;
                    state <= (op_q == OP_DIV) ? ST_DIV : ST_Z;
                end
                ST_Z: begin
                    if (op_q == OP_MUL) begin
                        z_q  <= prod[DATA_W-1:0];
                        hi_q <= prod[2*DATA_W-1:DATA_W];
                        lo_q <= prod[DATA_W-1:0];
                    end else begin
                        z_q <= alu_res;
                    end
                    state <= ST_WB;
                end
                ST_DIV: begin
                    if (div_valid) begin
                        state <= ST_WB;
                    end
                end
                ST_WB: begin
                    done_q <= 1'b1;
                    state  <= ST_IDLE;
                    if (bad_q) begin
                        err_q    <= 1'b1;
                        result_q <= '0;
                    end else begin
                        regs[rd_q] <= wb_val;
                        result_q   <= wb_val;
                        if (op_q == OP_DIV) begin
                            hi_q  <= div_rem;
                            lo_q  <= div_quo;
                            err_q <= div_zero;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_bus_datapath.sv
// Directed bench for seq_bus_datapath: hand-computed results, latencies, HI/LO and
// register contents, including divide-by-zero, MIN/-1 and reset mid-divide.
module tb_seq_bus_datapath;
    import seq_datapath_pkg::*;

    localparam int W  = 32;
    localparam int NR = 16;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  hi_val;
    logic [W-1:0]  lo_val;
    logic [RW-1:0] dbg_addr;
    logic [W-1:0]  dbg_data;
    state_e        dbg_state;

    seq_bus_datapath_if #(.DATA_W(W), .RA_W(RW)) bus ();

    seq_bus_datapath #(.DATA_W(W), .NUM_REGS(NR)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .hi_val    (hi_val),
        .lo_val    (lo_val),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [RW-1:0] idx, input logic [W-1:0] exp);
        dbg_addr = idx;
        #1;
        check(tag, dbg_data, exp);
    endtask

    // Presents one operation, holds it until the accept edge, then withdraws it.
    task automatic send(input logic [3:0] code, input logic [RW-1:0] rd, input logic [RW-1:0] rs,
                        input logic [RW-1:0] rt, input logic [W-1:0] imm, input bit scramble);
        int guard;
        @(negedge clk);
        bus.op_code  = code;
        bus.op_rd    = rd;
        bus.op_rs    = rs;
        bus.op_rt    = rt;
        bus.op_imm   = imm;
        bus.op_valid = 1'b1;
        guard = 0;
        while (!bus.op_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.op_valid = 1'b0;
        if (scramble) begin
            bus.op_code = 4'($urandom_range(0, 15));
            bus.op_rd   = RW'($urandom_range(0, NR - 1));
            bus.op_rs   = RW'($urandom_range(0, NR - 1));
            bus.op_rt   = RW'($urandom_range(0, NR - 1));
            bus.op_imm  = W'($urandom());
        end
    endtask

    // Counts edges after the accept edge until done; -1 if it never arrives.
    task automatic wait_done(output int lat, output logic e, output logic [W-1:0] r);
        lat = -1;
        e   = 1'bx;
        r   = 'x;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = i;
                e   = bus.err;
                r   = bus.result;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] code, input logic [RW-1:0] rd,
                          input logic [RW-1:0] rs, input logic [RW-1:0] rt, input logic [W-1:0] imm,
                          input int exp_lat, input logic exp_err, input logic [W-1:0] exp_res,
                          input bit scramble);
        int lat;
        logic e;
        logic [W-1:0] r;
        exp_q.push_back(exp_res);
        send(code, rd, rs, rt, imm, scramble);
        wait_done(lat, e, r);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_err"}, e, exp_err);
        check({tag, "_res"}, r, exp_q.pop_front());
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit seen_done;
        reset        = 1'b0;
        bus.op_valid = 1'b0;
        bus.op_code  = '0;
        bus.op_rd    = '0;
        bus.op_rs    = '0;
        bus.op_rt    = '0;
        bus.op_imm   = '0;
        dbg_addr     = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", bus.op_ready, 1'b1);
        check("rst_done", bus.done, 1'b0);
        check("rst_err", bus.err, 1'b0);
        check("rst_result", bus.result, '0);
        check("rst_hi", hi_val, '0);
        check("rst_lo", lo_val, '0);
        check("rst_dbg", dbg_data, '0);
        check("rst_state", dbg_state, ST_IDLE);
        @(negedge clk);
        reset = 1'b1;

        // LDI, LDI, ADD
        run_op("ldi_r1", 4'd12, 4'd1, 4'd0, 4'd0, 32'd7, 1, 1'b0, 32'd7, 1'b0);
        run_op("ldi_r2", 4'd12, 4'd2, 4'd0, 4'd0, 32'd5, 1, 1'b0, 32'd5, 1'b0);
        run_op("add", 4'd0, 4'd3, 4'd1, 4'd2, 32'd0, 3, 1'b0, 32'd12, 1'b0);
        check("ready_with_done", bus.op_ready, 1'b1);
        check_reg("dbg_r3", 4'd3, 32'd12);
        @(posedge clk);
        #1;
        check("done_pulse", bus.done, 1'b0);

        // Signed MUL
        run_op("ldi_min", 4'd12, 4'd1, 4'd0, 4'd0, 32'h8000_0000, 1, 1'b0, 32'h8000_0000, 1'b0);
        run_op("ldi_m1", 4'd12, 4'd2, 4'd0, 4'd0, 32'hFFFF_FFFF, 1, 1'b0, 32'hFFFF_FFFF, 1'b0);
        run_op("mul", 4'd10, 4'd4, 4'd1, 4'd2, 32'd0, 3, 1'b0, 32'h8000_0000, 1'b0);
        check("mul_hi", hi_val, 32'h0000_0000);
        check("mul_lo", lo_val, 32'h8000_0000);
        check_reg("dbg_r4", 4'd4, 32'h8000_0000);

        // Signed DIV -7 / 2, then MFHI
        run_op("ldi_n7", 4'd12, 4'd1, 4'd0, 4'd0, 32'hFFFF_FFF9, 1, 1'b0, 32'hFFFF_FFF9, 1'b0);
        run_op("ldi_2", 4'd12, 4'd2, 4'd0, 4'd0, 32'd2, 1, 1'b0, 32'd2, 1'b0);
        run_op("div", 4'd11, 4'd5, 4'd1, 4'd2, 32'd0, 34, 1'b0, 32'hFFFF_FFFD, 1'b0);
        check("div_lo", lo_val, 32'hFFFF_FFFD);
        check("div_hi", hi_val, 32'hFFFF_FFFF);
        run_op("mfhi", 4'd13, 4'd6, 4'd0, 4'd0, 32'd0, 1, 1'b0, 32'hFFFF_FFFF, 1'b0);
        check_reg("dbg_r6", 4'd6, 32'hFFFF_FFFF);

        // Divide by zero, then a normal op
        run_op("ldi_0", 4'd12, 4'd2, 4'd0, 4'd0, 32'd0, 1, 1'b0, 32'd0, 1'b0);
        run_op("div0", 4'd11, 4'd7, 4'd1, 4'd2, 32'd0, 34, 1'b1, 32'hFFFF_FFFF, 1'b0);
        check("div0_lo", lo_val, 32'hFFFF_FFFF);
        check("div0_hi", hi_val, 32'hFFFF_FFF9);
        check_reg("dbg_r7", 4'd7, 32'hFFFF_FFFF);
        run_op("after_div0", 4'd12, 4'd8, 4'd0, 4'd0, 32'h1234, 1, 1'b0, 32'h1234, 1'b0);

        // MIN / -1, then MFLO
        run_op("ldi_min2", 4'd12, 4'd1, 4'd0, 4'd0, 32'h8000_0000, 1, 1'b0, 32'h8000_0000, 1'b0);
        run_op("ldi_m1b", 4'd12, 4'd2, 4'd0, 4'd0, 32'hFFFF_FFFF, 1, 1'b0, 32'hFFFF_FFFF, 1'b0);
        run_op("div_min", 4'd11, 4'd14, 4'd1, 4'd2, 32'd0, 34, 1'b0, 32'h8000_0000, 1'b0);
        check("div_min_hi", hi_val, 32'h0);
        run_op("mflo", 4'd14, 4'd0, 4'd0, 4'd0, 32'd0, 1, 1'b0, 32'h8000_0000, 1'b0);

        // Rotates and shifts; ROR has its inputs scrambled after accept
        run_op("ldi_rot", 4'd12, 4'd1, 4'd0, 4'd0, 32'h8000_0001, 1, 1'b0, 32'h8000_0001, 1'b0);
        run_op("ldi_sh1", 4'd12, 4'd2, 4'd0, 4'd0, 32'd1, 1, 1'b0, 32'd1, 1'b0);
        run_op("rol", 4'd6, 4'd9, 4'd1, 4'd2, 32'd0, 3, 1'b0, 32'h0000_0003, 1'b0);
        run_op("ror", 4'd7, 4'd10, 4'd1, 4'd2, 32'd0, 3, 1'b0, 32'hC000_0000, 1'b1);
        run_op("shl", 4'd4, 4'd11, 4'd1, 4'd2, 32'd0, 3, 1'b0, 32'h0000_0002, 1'b0);
        run_op("ldi_33", 4'd12, 4'd12, 4'd0, 4'd0, 32'd33, 1, 1'b0, 32'd33, 1'b0);
        run_op("shr_mod", 4'd5, 4'd13, 4'd1, 4'd12, 32'd0, 3, 1'b0, 32'h4000_0000, 1'b0);
        run_op("sub", 4'd1, 4'd11, 4'd2, 4'd1, 32'd0, 3, 1'b0, 32'h8000_0000, 1'b0);
        run_op("add_self", 4'd0, 4'd2, 4'd2, 4'd2, 32'd0, 3, 1'b0, 32'd2, 1'b0);
        run_op("neg", 4'd8, 4'd15, 4'd1, 4'd0, 32'd0, 3, 1'b0, 32'h7FFF_FFFF, 1'b0);
        run_op("not_self", 4'd9, 4'd15, 4'd15, 4'd0, 32'd0, 3, 1'b0, 32'h8000_0000, 1'b0);
        run_op("and", 4'd2, 4'd3, 4'd1, 4'd13, 32'd0, 3, 1'b0, 32'h0000_0000, 1'b0);
        run_op("or", 4'd3, 4'd3, 4'd1, 4'd13, 32'd0, 3, 1'b0, 32'hC000_0001, 1'b0);
        check("alu_keeps_hi", hi_val, 32'h0);
        check("alu_keeps_lo", lo_val, 32'h8000_0000);

        // Reset dropped after edge 10 of a DIV
        send(4'd11, 4'd5, 4'd1, 4'd13, 32'd0, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("mid_rst_ready", bus.op_ready, 1'b1);
        check("mid_rst_state", dbg_state, ST_IDLE);
        check("mid_rst_hi", hi_val, '0);
        check("mid_rst_lo", lo_val, '0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.done) seen_done = 1'b1;
        end
        check("mid_rst_no_done", seen_done, 1'b0);
        check("mid_rst_err", bus.err, 1'b0);
        for (int i = 0; i < NR; i++) begin
            check_reg($sformatf("mid_rst_r%0d", i), RW'(i), '0);
        end

        // Illegal opcode: err with no register change
        run_op("ldi_55", 4'd12, 4'd3, 4'd0, 4'd0, 32'h55, 1, 1'b0, 32'h55, 1'b0);
        run_op("illegal", 4'd15, 4'd3, 4'd1, 4'd2, 32'd0, 1, 1'b1, 32'h0, 1'b0);
        check_reg("illegal_r3", 4'd3, 32'h55);
        check("illegal_hi", hi_val, '0);
        check("illegal_lo", lo_val, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
